// File: rtl/ddr4_cmd_driver.sv
// ddr4_cmd_driver
//   Host-side DDR4 command/data sequencer. Converts single read/write burst
//   requests into ACT/RD/WR/PRE command cycles and drives or captures the
//   DQ/DQS burst with tRP/tRCD/CL/CWL spacing. Honours the DIMM stall input.
//   Optional feature macro: OPEN_PAGE_EN (open-page policy with per-bank
//   open-row table). Undefined: closed page with auto-precharge + RECOVER.
// Ports
//   ck2x, reset_n            : clock, synchronous active-low reset
//   req_valid/req_ready      : request handshake (req_wr, req_bg/ba/row/col,
//                              req_wdata beat 0 in LSBs)
//   rsp_valid, rsp_rdata     : read completion pulse + held read burst
//   stall                    : DIMM busy, freezes command-side progress
//   act_n, A, bg, ba, cs_n,
//   cke                      : DDR4 command bus
//   dq_out, dq_oe, dq_in     : data bus
//   dqs_tp, dqs_cn, dqs_oe   : write strobes
module ddr4_cmd_driver #(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned DQWIDTH   = 64,
  parameter int unsigned CHIPS     = 16,
  parameter int unsigned BL        = 8,
  parameter int unsigned TRP       = 4,
  parameter int unsigned TRCD      = 4,
  parameter int unsigned CL        = 6,
  parameter int unsigned CWL       = 5
) (
  input  logic                  ck2x,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [COLWIDTH-1:0]   req_col,
  input  logic [DQWIDTH*BL-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DQWIDTH*BL-1:0] rsp_rdata,
  input  logic                  stall,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH-1:0]    ba,
  output logic                  cs_n,
  output logic                  cke,
  output logic [DQWIDTH-1:0]    dq_out,
  output logic                  dq_oe,
  input  logic [DQWIDTH-1:0]    dq_in,
  output logic [CHIPS-1:0]      dqs_tp,
  output logic [CHIPS-1:0]      dqs_cn,
  output logic                  dqs_oe
);

  localparam int unsigned BURSTW = DQWIDTH * BL;
  localparam int unsigned TMAXA  = (TRP > TRCD) ? TRP : TRCD;
  localparam int unsigned TMAXB  = (CL > CWL) ? CL : CWL;
  localparam int unsigned TMAX   = (TMAXA > TMAXB) ? TMAXA : TMAXB;
  localparam int unsigned CNTW   = $clog2(TMAX + 1);
  localparam int unsigned BEATW  = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BL - 1);

`ifdef OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
  localparam int unsigned BANKGROUPS    = 2**BGWIDTH;
  localparam int unsigned BANKSPERGROUP = 2**BAWIDTH;
  localparam int unsigned BANKS         = BANKGROUPS * BANKSPERGROUP;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_LAT, S_BURST, S_RECOVER
  } state_t;

  state_t state, state_next, first_state;
  logic [CNTW-1:0]  cnt, cnt_next, first_cnt, cas_cnt;
  logic [BEATW-1:0] beat, beat_next;
  logic             ready_q, accept, hold;

  // latched request
  logic                 wr_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [COLWIDTH-1:0]  col_q;
  logic [BURSTW-1:0]    wdata_q, rd_buf;

  // request fields as seen by the command issued this edge
  logic                 cur_wr;
  logic [BGWIDTH-1:0]   cur_bg;
  logic [BAWIDTH-1:0]   cur_ba;
  logic [ADDRWIDTH-1:0] cur_row;
  logic [COLWIDTH-1:0]  cur_col;

  // next values of registered outputs
  logic                 cs_n_d, act_n_d, dq_oe_d, dqs_oe_d, rsp_valid_d, ready_d;
  logic [ADDRWIDTH-1:0] a_d;
  logic [BGWIDTH-1:0]   bg_d;
  logic [BAWIDTH-1:0]   ba_d;
  logic [DQWIDTH-1:0]   dq_out_d;
  logic [CHIPS-1:0]     dqs_tp_d;
  logic [BURSTW-1:0]    rd_buf_d, rsp_rdata_d;

  assign req_ready = ready_q & ~stall;
  assign accept    = req_valid & req_ready;
  // CAS already launched: WAIT_LAT/BURST/CAS exits cannot slip
  assign hold      = stall && (state inside {S_IDLE, S_PRE, S_WAIT_RP, S_ACT,
                                             S_WAIT_RCD, S_RECOVER});

  assign cur_wr  = accept ? req_wr  : wr_q;
  assign cur_bg  = accept ? req_bg  : bg_q;
  assign cur_ba  = accept ? req_ba  : ba_q;
  assign cur_row = accept ? req_row : row_q;
  assign cur_col = accept ? req_col : col_q;
  assign cas_cnt = cur_wr ? CNTW'(CWL - 1) : CNTW'(CL - 1);

`ifdef OPEN_PAGE_EN
  logic [BANKS-1:0]             row_vld;
  logic [ADDRWIDTH-1:0]         row_tab [BANKS];
  logic [BGWIDTH+BAWIDTH-1:0]   req_bank, cur_bank;

  assign req_bank = {req_bg, req_ba};
  assign cur_bank = {cur_bg, cur_ba};

  // page policy: hit -> CAS, closed -> ACT, conflict -> PRE
  always_comb begin
    first_state = S_ACT;
    first_cnt   = CNTW'(TRCD - 1);
    if (row_vld[req_bank]) begin
      if (row_tab[req_bank] == req_row) begin
        first_state = S_CAS;
        first_cnt   = cas_cnt;
      end else begin
        first_state = S_PRE;
        first_cnt   = CNTW'(TRP - 1);
      end
    end
  end

  // open-row table tracks issued ACT/PRE
  always_ff @(posedge ck2x) begin
    if (!reset_n) begin
      row_vld <= '0;
    end else if (state_next != state) begin
      if (state_next == S_ACT) begin
        row_vld[cur_bank] <= 1'b1;
        row_tab[cur_bank] <= cur_row;
      end else if (state_next == S_PRE) begin
        row_vld[cur_bank] <= 1'b0;
      end
    end
  end
`else
  assign first_state = S_ACT;
  assign first_cnt   = CNTW'(TRCD - 1);
`endif

  // state register
  always_ff @(posedge ck2x) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      beat  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      beat  <= beat_next;
    end
  end

  // next-state: wait counters are loaded when the command issues
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    beat_next  = beat;
    if (!hold) begin
      case (state)
        S_IDLE: if (accept) begin
          state_next = first_state;
          cnt_next   = first_cnt;
        end
        S_PRE, S_WAIT_RP: if (cnt == '0) begin
          state_next = S_ACT;
          cnt_next   = CNTW'(TRCD - 1);
        end else begin
          state_next = S_WAIT_RP;
          cnt_next   = cnt - CNTW'(1);
        end
        S_ACT, S_WAIT_RCD: if (cnt == '0) begin
          state_next = S_CAS;
          cnt_next   = cas_cnt;
        end else begin
          state_next = S_WAIT_RCD;
          cnt_next   = cnt - CNTW'(1);
        end
        S_CAS, S_WAIT_LAT: if (cnt == '0) begin
          state_next = S_BURST;
          beat_next  = '0;
        end else begin
          state_next = S_WAIT_LAT;
          cnt_next   = cnt - CNTW'(1);
        end
        S_BURST: if (beat == LAST_BEAT) begin
          state_next = OPEN_PAGE ? S_IDLE : S_RECOVER;
          cnt_next   = CNTW'(TRP - 1);
        end else begin
          beat_next  = beat + BEATW'(1);
        end
        S_RECOVER: if (cnt == '0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next   = cnt - CNTW'(1);
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // output decode for the coming cycle
  always_comb begin
    cs_n_d      = 1'b1;
    act_n_d     = 1'b1;
    a_d         = '0;
    bg_d        = bg;
    ba_d        = ba;
    dq_out_d    = '0;
    dq_oe_d     = 1'b0;
    dqs_oe_d    = 1'b0;
    dqs_tp_d    = '0;
    rd_buf_d    = rd_buf;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    ready_d     = (state_next == S_IDLE);
    // a command issues only on entry into a command state
    if (state_next != state) begin
      case (state_next)
        S_PRE: begin
          cs_n_d = 1'b0;
          bg_d   = cur_bg;
          ba_d   = cur_ba;
          a_d[15] = 1'b1;
        end
        S_ACT: begin
          cs_n_d  = 1'b0;
          act_n_d = 1'b0;
          bg_d    = cur_bg;
          ba_d    = cur_ba;
          a_d     = cur_row;
        end
        S_CAS: begin
          cs_n_d = 1'b0;
          bg_d   = cur_bg;
          ba_d   = cur_ba;
          a_d[COLWIDTH-1:0] = cur_col;
          a_d[16] = 1'b1;
          a_d[14] = ~cur_wr;
          a_d[10] = ~OPEN_PAGE;
        end
        default: ;
      endcase
    end
    if (state_next == S_BURST && wr_q) begin
      dq_oe_d  = 1'b1;
      dqs_oe_d = 1'b1;
      dq_out_d = wdata_q[DQWIDTH*beat_next +: DQWIDTH];
      dqs_tp_d = beat_next[0] ? '0 : '1;
    end
    if (state == S_BURST && !wr_q) begin
      rd_buf_d[DQWIDTH*beat +: DQWIDTH] = dq_in;
      if (beat == LAST_BEAT) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd_buf_d;
      end
    end
  end

  // output and request registers
  always_ff @(posedge ck2x) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      act_n     <= 1'b1;
      A         <= '0;
      bg        <= '0;
      ba        <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      dqs_oe    <= 1'b0;
      dqs_tp    <= '0;
      dqs_cn    <= '1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rd_buf    <= '0;
      wr_q      <= 1'b0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
    end else begin
      ready_q   <= ready_d;
      cke       <= 1'b1;
      cs_n      <= cs_n_d;
      act_n     <= act_n_d;
      A         <= a_d;
      bg        <= bg_d;
      ba        <= ba_d;
      dq_out    <= dq_out_d;
      dq_oe     <= dq_oe_d;
      dqs_oe    <= dqs_oe_d;
      dqs_tp    <= dqs_tp_d;
      dqs_cn    <= ~dqs_tp_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rd_buf    <= rd_buf_d;
      if (accept) begin
        wr_q    <= req_wr;
        bg_q    <= req_bg;
        ba_q    <= req_ba;
        row_q   <= req_row;
        col_q   <= req_col;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_driver.sv
// Testbench for ddr4_cmd_driver: directed and randomized requests checked
// against a cycle-formula reference model with an open-row table.
module tb_ddr4_cmd_driver;

  localparam int unsigned DQW  = 64;
  localparam int unsigned BLEN = 8;
  localparam int unsigned TRP  = 4;
  localparam int unsigned TRCD = 4;
  localparam int unsigned CL   = 6;
  localparam int unsigned CWL  = 5;
  localparam int unsigned BW   = DQW * BLEN;
`ifdef OPEN_PAGE_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif
  localparam int K_PRE = 0;
  localparam int K_ACT = 1;
  localparam int K_CAS = 2;

  logic            ck2x = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_wr = 1'b0;
  logic [1:0]      req_bg = '0;
  logic [1:0]      req_ba = '0;
  logic [16:0]     req_row = '0;
  logic [9:0]      req_col = '0;
  logic [BW-1:0]   req_wdata = '0;
  logic            rsp_valid;
  logic [BW-1:0]   rsp_rdata;
  logic            stall = 1'b0;
  logic            act_n;
  logic [16:0]     A;
  logic [1:0]      bg;
  logic [1:0]      ba;
  logic            cs_n;
  logic            cke;
  logic [DQW-1:0]  dq_out;
  logic            dq_oe;
  logic [DQW-1:0]  dq_in = '0;
  logic [15:0]     dqs_tp;
  logic [15:0]     dqs_cn;
  logic            dqs_oe;

  ddr4_cmd_driver #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10), .DQWIDTH(DQW),
    .CHIPS(16), .BL(BLEN), .TRP(TRP), .TRCD(TRCD), .CL(CL), .CWL(CWL)
  ) dut (
    .ck2x(ck2x), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .stall(stall), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .cs_n(cs_n), .cke(cke), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
    .dqs_tp(dqs_tp), .dqs_cn(dqs_cn), .dqs_oe(dqs_oe)
  );

  always #5 ck2x = ~ck2x;

  int n_checks = 0;
  int n_fail   = 0;

  // reference open-row table
  bit          tab_vld [16];
  logic [16:0] tab_row [16];

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    stall     = 1'b0;
    repeat (ncyc) @(negedge ck2x);
    chk("rst_cmd", BW'({cke, req_ready, cs_n, act_n, A, bg, ba}),
        BW'({1'b0, 1'b0, 1'b1, 1'b1, 17'h0, 2'h0, 2'h0}));
    chk("rst_dq", BW'({dq_out, dq_oe, dqs_oe, dqs_tp, dqs_cn, rsp_valid}),
        BW'({64'h0, 1'b0, 1'b0, 16'h0, 16'hFFFF, 1'b0}));
    chk("rst_rdata", rsp_rdata, BW'(0));
    reset_n = 1'b1;
    @(negedge ck2x);
    chk("rst_release", BW'({cke, req_ready}), BW'(2'b11));
    for (int b = 0; b < 16; b++) tab_vld[b] = 1'b0;
  endtask

  // One request; slen = stall cycles starting at cycle 2; abort_at>0 asserts reset there.
  task automatic run_req(input bit wr, input logic [1:0] bgv, input logic [1:0] bav,
                         input logic [16:0] row, input logic [9:0] col,
                         input int slen, input int abort_at);
    logic [BW-1:0] wd, rd_exp;
    logic [16:0]   ea;
    logic [15:0]   tp;
    int ecyc [3];
    int ekind [3];
    int ncmd, b, dstart, ready_c, waited, k;
    bit in_burst;

    b = int'({bgv, bav});
    for (int w = 0; w < int'(BW / 32); w++) begin
      wd[32*w +: 32]     = $urandom();
      rd_exp[32*w +: 32] = $urandom();
    end
    ncmd = 0;
    if (OPEN && tab_vld[b] && tab_row[b] == row) begin
      ecyc[0] = 1; ekind[0] = K_CAS; ncmd = 1;
    end else if (OPEN && tab_vld[b]) begin
      ecyc[0] = 1;                         ekind[0] = K_PRE;
      ecyc[1] = 1 + int'(TRP) + slen;        ekind[1] = K_ACT;
      ecyc[2] = ecyc[1] + int'(TRCD);        ekind[2] = K_CAS;
      ncmd = 3;
    end else begin
      ecyc[0] = 1;                         ekind[0] = K_ACT;
      ecyc[1] = 1 + int'(TRCD) + slen;       ekind[1] = K_CAS;
      ncmd = 2;
    end
    if (OPEN) begin
      tab_vld[b] = 1'b1;
      tab_row[b] = row;
    end
    dstart  = ecyc[ncmd-1] + int'(wr ? CWL : CL);
    ready_c = dstart + int'(BLEN) + (OPEN ? 0 : int'(TRP));

    @(negedge ck2x);
    waited = 0;
    while (!req_ready && waited < 60) begin
      @(negedge ck2x);
      waited++;
    end
    chk("ready_wait", BW'(req_ready), BW'(1'b1));
    req_wr = wr; req_bg = bgv; req_ba = bav; req_row = row; req_col = col;
    req_wdata = wd;
    req_valid = 1'b1;

    for (int i = 1; i <= ready_c + 1; i++) begin
      @(negedge ck2x);
      if (i == abort_at) begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        stall = 1'b0;
        break;
      end
      if (i == 1) req_valid = 1'b0;
      k = -1;
      for (int j = 0; j < ncmd; j++) if (ecyc[j] == i) k = j;
      if (k >= 0) begin
        ea = '0;
        if (ekind[k] == K_ACT) ea = row;
        else if (ekind[k] == K_PRE) ea[15] = 1'b1;
        else begin
          ea[9:0] = col;
          ea[16]  = 1'b1;
          ea[14]  = ~wr;
          ea[10]  = ~OPEN;
        end
        chk($sformatf("cmd%0d_c%0d", ekind[k], i), BW'({cs_n, act_n, A, bg, ba}),
            BW'({1'b0, (ekind[k] != K_ACT), ea, bgv, bav}));
      end else begin
        chk($sformatf("des_c%0d", i), BW'({cs_n, act_n, A}), BW'({1'b1, 1'b1, 17'h0}));
      end
      in_burst = (i >= dstart) && (i < dstart + int'(BLEN));
      chk($sformatf("oe_c%0d", i), BW'({dq_oe, dqs_oe}), BW'((wr && in_burst) ? 2'b11 : 2'b00));
      if (wr && in_burst) begin
        tp = ((i - dstart) % 2 == 0) ? 16'hFFFF : 16'h0000;
        chk($sformatf("wbeat_c%0d", i), BW'({dqs_tp, dqs_cn, dq_out}),
            BW'({tp, ~tp, wd[(i-dstart)*64 +: 64]}));
      end
      chk($sformatf("rsp_valid_c%0d", i), BW'(rsp_valid), BW'(!wr && i == dstart + int'(BLEN)));
      if (!wr && i == dstart + int'(BLEN)) chk("rdata", rsp_rdata, rd_exp);
      chk($sformatf("ready_c%0d", i), BW'(req_ready), BW'(i >= ready_c));
      stall = (i >= 2) && (i <= slen + 1);
      if (!wr && in_burst) dq_in = rd_exp[(i-dstart)*64 +: 64];
      else dq_in = {$urandom(), $urandom()};
    end
    req_valid = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit          wr;
    logic [1:0]  bgv, bav;
    logic [16:0] row;
    int          slen;

    do_reset(3);
    // directed scenarios
    run_req(1'b1, 2'd1, 2'd2, 17'h1A5, 10'h040, 0, 0);
    run_req(1'b0, 2'd1, 2'd2, 17'h1A5, 10'h041, 0, 0);
    run_req(1'b0, 2'd1, 2'd2, 17'h1A6, 10'h042, 0, 0);
    run_req(1'b0, 2'd0, 2'd1, 17'h033, 10'h010, 10, 0);
    run_req(1'b1, 2'd2, 2'd3, 17'h0FF, 10'h3FF, 0, 0);
    run_req(1'b1, 2'd2, 2'd3, 17'h0FF, 10'h000, 0, 0);
    // randomized traffic over a few banks and rows
    for (int n = 0; n < 30; n++) begin
      wr   = 1'($urandom_range(0, 1));
      bgv  = 2'($urandom_range(0, 1));
      bav  = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0;
      case ($urandom_range(0, 2))
        0: row = 17'h1A5;
        1: row = 17'h1A6;
        default: row = 17'($urandom());
      endcase
      slen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_req(wr, bgv, bav, row, 10'($urandom()), slen, 0);
    end
    // abort mid read burst: no response may follow, table is cleared
    run_req(1'b0, 2'd3, 2'd0, 17'h055, 10'h020, 0, 0);
    run_req(1'b0, 2'd3, 2'd0, 17'h056, 10'h021, 0, 14);
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      @(negedge ck2x);
      chk("post_abort", BW'({rsp_valid, cs_n}), BW'(2'b01));
    end
    run_req(1'b0, 2'd3, 2'd0, 17'h056, 10'h022, 0, 0);
    run_req(1'b1, 2'd1, 2'd2, 17'h1A5, 10'h040, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
